// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage. Drives the PC against a variable
//             latency instruction memory (req/gnt/rvalid), buffers returned
//             words with their PCs in a small FIFO and hands them to decode
//             over a valid/ready handshake. Redirect flushes all in-flight
//             work and restarts fetching at a new PC.
//  Options  : FETCH_BYPASS_EN - when defined, a response arriving while the
//             FIFO is empty is presented to decode in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          PC_W     = 8,
    parameter int          INS_W    = 32,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [INS_W-1:0]         imem_rdata,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [INS_W-1:0]         inst,
    output logic [PC_W-1:0]          inst_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0]  c_reset_pc = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  c_pc_step  = PC_W'(4);

    // IDLE: may request. WAIT: one request outstanding, response wanted.
    // DROP: one request outstanding whose response must be discarded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [PC_W-1:0]    r_fetch_pc;
    logic [PC_W-1:0]    r_pending_pc;

    logic [INS_W-1:0]   r_mem_inst [DEPTH];
    logic [PC_W-1:0]    r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_not_full;
    logic               w_accept;
    logic               w_resp;
    logic               w_head_valid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    // Handshake decode: request, accept, push/pop and the decode-side view.
    // The outstanding request owns a FIFO slot, so requesting only while not
    // full guarantees the response always has room.
    always_comb begin
        w_not_full   = (r_count != c_depth);
        imem_req     = (r_state == S_IDLE) && w_not_full && !redirect && !reset;
        w_accept     = imem_req && imem_gnt;
        w_resp       = (r_state == S_WAIT) && imem_rvalid && !redirect;
        w_head_valid = (r_count != '0);
`ifdef FETCH_BYPASS_EN
        w_bypass     = !w_head_valid && w_resp;
`else
        w_bypass     = 1'b0;
`endif
        inst_valid   = (w_head_valid && !redirect) || w_bypass;
        inst         = w_bypass ? imem_rdata   : r_mem_inst[r_rd_ptr];
        inst_pc      = w_bypass ? r_pending_pc : r_mem_pc[r_rd_ptr];
        // A bypassed word never sits in the FIFO, so pop only from storage.
        w_pop        = w_head_valid && !redirect && inst_ready;
        // A bypassed word consumed this cycle is not written.
        w_push       = w_resp && !(w_bypass && inst_ready);
        imem_addr    = r_fetch_pc;
        fifo_count   = r_count;
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a redirect while a request is outstanding turns the
    // pending response into one to be discarded, unless it arrives now.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = S_IDLE;
                end else if (redirect) begin
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Fetch PC and the PC of the outstanding request; redirect wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc   <= c_reset_pc;
            r_pending_pc <= '0;
        end else if (redirect) begin
            r_fetch_pc   <= redirect_pc;
        end else if (w_accept) begin
            r_pending_pc <= r_fetch_pc;
            r_fetch_pc   <= r_fetch_pc + c_pc_step;
        end
    end

    // FIFO pointers and occupancy; redirect flushes and suppresses any pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_pending_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed bench for fetch_queue. A memory responder answers
//             accepted requests after a programmable latency; expected
//             {pc, word} pairs are queued by the stimulus and checked by an
//             independent monitor whenever decode accepts an instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int PC_W  = 8;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   imem_req;
    logic [PC_W-1:0]        imem_addr;
    logic                   imem_gnt = 1'b0;
    logic                   imem_rvalid = 1'b0;
    logic [INS_W-1:0]       imem_rdata = '0;
    logic                   redirect = 1'b0;
    logic [PC_W-1:0]        redirect_pc = '0;
    logic                   inst_valid;
    logic                   inst_ready = 1'b0;
    logic [INS_W-1:0]       inst;
    logic [PC_W-1:0]        inst_pc;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    logic [PC_W+INS_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_queue #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fifo_count  (fifo_count)
    );

    // Memory contents: a recognisable tag with the address in the low byte.
    function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {24'hC0DE5A, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [PC_W-1:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    // Wait (bounded) for a request; returns at the negedge of that cycle.
    task automatic wait_req(input string nm, input logic [PC_W-1:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                seen = 1'b1;
                break;
            end
            next();
        end
        chk({nm, "_req"}, 64'(seen), 64'd1);
        if (seen) chk(nm, 64'(imem_addr), 64'(a));
    endtask

    task automatic wait_count(input string nm, input int n);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (int'(fifo_count) == n) break;
            next();
        end
        chk(nm, 64'(fifo_count), 64'(n));
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next();
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    // Memory responder: answers each accepted request after lat cycles.
    initial begin : responder
        int                cd;
        logic              busy;
        logic [PC_W-1:0]   ra;
        busy = 1'b0;
        cd   = 0;
        ra   = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (busy) begin
                cd--;
                if (cd <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(ra);
                    busy        = 1'b0;
                end
            end
            @(negedge clk);
            if (!reset && imem_req && imem_gnt) begin
                busy = 1'b1;
                cd   = lat;
                ra   = imem_addr;
            end
        end
    end

    // Monitor: every instruction accepted by decode must be the next expected.
    initial begin : monitor
        logic [PC_W+INS_W-1:0] e;
        forever begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc 0x%0h inst 0x%0h expected none", inst_pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", 64'(inst_pc), 64'(e[PC_W+INS_W-1:INS_W]));
                    chk("pop_inst", 64'(inst), 64'(e[INS_W-1:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        reset      = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        lat        = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req",   64'(imem_req),   64'd0);
        chk("rst_addr",  64'(imem_addr),  64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_inst",  64'(inst),       64'd0);
        chk("rst_pc",    64'(inst_pc),    64'd0);
        next();
        reset = 1'b0;

        // Streaming with k=1: one instruction every two cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_req",  64'(imem_req),  64'd1);
            chk("t1_addr", 64'(imem_addr), 64'(4 * i));
            push_exp(8'(4 * i));
            next();
            @(negedge clk);
`ifdef FETCH_BYPASS_EN
            chk("t1_valid_rv", 64'(inst_valid), 64'd1);
`else
            chk("t1_valid_rv", 64'(inst_valid), 64'd0);
`endif
            next();
        end
        imem_gnt = 1'b0;
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        chk("t1_count", 64'(fifo_count), 64'd0);
`else
        chk("t1_count", 64'(fifo_count), 64'd1);
`endif
        next();

        // Fill to full with decode stalled, then a single pop.
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req("t2_addr", 8'(16 + 4 * i));
            push_exp(8'(16 + 4 * i));
            next();
        end
        wait_count("t2_full", 4);
        chk("t2_full_req", 64'(imem_req), 64'd0);
        repeat (2) begin
            next();
            @(negedge clk);
            chk("t2_full_req", 64'(imem_req), 64'd0);
        end
        next();
        inst_ready = 1'b1;
        @(negedge clk);
        next();
        inst_ready = 1'b0;
        @(negedge clk);
        chk("t2_count3", 64'(fifo_count), 64'd3);
        chk("t2_rereq",  64'(imem_req),   64'd1);
        chk("t2_readdr", 64'(imem_addr),  64'h20);
        push_exp(8'h20);
        next();
        imem_gnt = 1'b0;
        next();
        @(negedge clk);
        chk("t2_refull", 64'(fifo_count), 64'd4);
        next();
        inst_ready = 1'b1;
        drain("t2_drain");
        @(negedge clk);
        chk("t2_empty", 64'(fifo_count), 64'd0);

        // Redirect while WAIT; late response must be dropped.
        next();
        lat      = 3;
        imem_gnt = 1'b1;
        wait_req("t3_addr", 8'h24);
        next();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clk);
        chk("t3_req_redir", 64'(imem_req), 64'd0);
        next();
        redirect = 1'b0;
        @(negedge clk);
        chk("t3_drop_req", 64'(imem_req), 64'd0);
        next();
        @(negedge clk);
        chk("t3_rv_req", 64'(imem_req),   64'd0);
        chk("t3_rv_cnt", 64'(fifo_count), 64'd0);
        next();
        lat      = 1;
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("t3_cnt",      64'(fifo_count), 64'd0);
        chk("t3_new_req",  64'(imem_req),   64'd1);
        chk("t3_new_addr", 64'(imem_addr),  64'h40);
        push_exp(8'h40);
        next();
        imem_gnt = 1'b0;
        drain("t3_drain");

        // Redirect coinciding with a response while two entries are queued.
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        wait_req("t4_a0", 8'h44);
        next();
        next();
        wait_req("t4_a1", 8'h48);
        next();
        next();
        wait_req("t4_a2", 8'h4C);
        next();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        inst_ready  = 1'b1;
        @(negedge clk);
        chk("t4_cnt_before", 64'(fifo_count), 64'd2);
        chk("t4_valid_redir", 64'(inst_valid), 64'd0);
        next();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("t4_cnt_after", 64'(fifo_count), 64'd0);
        chk("t4_req",       64'(imem_req),   64'd1);
        chk("t4_addr",      64'(imem_addr),  64'h80);
        push_exp(8'h80);
        next();
        imem_gnt = 1'b0;
        drain("t4_drain");

        // PC wrap at the top of the 8-bit address space.
        redirect    = 1'b1;
        redirect_pc = 8'hFC;
        @(negedge clk);
        chk("t5_req_redir", 64'(imem_req), 64'd0);
        next();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        wait_req("t5_fc", 8'hFC);
        push_exp(8'hFC);
        next();
        next();
        wait_req("t5_wrap", 8'h00);
        push_exp(8'h00);
        next();
        imem_gnt = 1'b0;
        drain("t5_drain");

        // Response into an empty FIFO, decode ready then stalled.
        imem_gnt = 1'b1;
        wait_req("t6_addr", 8'h04);
        push_exp(8'h04);
        next();
        imem_gnt = 1'b0;
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        chk("t6_byp_valid", 64'(inst_valid), 64'd1);
        chk("t6_byp_pc",    64'(inst_pc),    64'h04);
        next();
        @(negedge clk);
        chk("t6_byp_cnt",   64'(fifo_count), 64'd0);
`else
        chk("t6_rv_valid",  64'(inst_valid), 64'd0);
        next();
        @(negedge clk);
        chk("t6_cnt",       64'(fifo_count), 64'd1);
        chk("t6_valid",     64'(inst_valid), 64'd1);
`endif
        next();
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        wait_req("t6_addr2", 8'h08);
        push_exp(8'h08);
        next();
        imem_gnt = 1'b0;
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        chk("t6_rv_valid2", 64'(inst_valid), 64'd1);
`else
        chk("t6_rv_valid2", 64'(inst_valid), 64'd0);
`endif
        chk("t6_rv_cnt2", 64'(fifo_count), 64'd0);
        next();
        @(negedge clk);
        chk("t6_cnt2",   64'(fifo_count), 64'd1);
        chk("t6_valid2", 64'(inst_valid), 64'd1);
        next();
        inst_ready = 1'b1;
        drain("t6_drain");

        // Reset with a request outstanding; the late response is ignored.
        lat      = 3;
        imem_gnt = 1'b1;
        wait_req("t7_addr", 8'h0C);
        next();
        imem_gnt = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("t7_rst_req",   64'(imem_req),   64'd0);
        chk("t7_rst_addr",  64'(imem_addr),  64'd0);
        chk("t7_rst_cnt",   64'(fifo_count), 64'd0);
        chk("t7_rst_valid", 64'(inst_valid), 64'd0);
        chk("t7_rst_inst",  64'(inst),       64'd0);
        chk("t7_rst_pc",    64'(inst_pc),    64'd0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("t7_rel_req",  64'(imem_req),  64'd1);
        chk("t7_rel_addr", 64'(imem_addr), 64'd0);
        next();
        @(negedge clk);
        chk("t7_rv_cnt", 64'(fifo_count), 64'd0);
        next();
        @(negedge clk);
        chk("t7_cnt",   64'(fifo_count), 64'd0);
        chk("t7_valid", 64'(inst_valid), 64'd0);
        chk("t7_req",   64'(imem_req),   64'd1);
        chk("t7_addr",  64'(imem_addr),  64'd0);

        next();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
